// File: rtl/db_key_extract.sv
`default_nettype none
// ============================================================================
// Module      : db_key_extract
// Description : Parses Ethernet/IPv4/UDP headers on a 64-bit AXI-Stream tap
//               and emits a direction-independent flow key for DNS traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module db_key_extract #(
    parameter int          KEY_SIZE  = 96,
    parameter logic [15:0] DNS_PORT  = 16'd53,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [63:0]          s_axis_tdata,
    input  logic [7:0]           s_axis_tkeep,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    output logic [KEY_SIZE-1:0]  out_key,
    output logic [3:0]           out_flag,
    output logic                 out_valid,
    output logic [CNT_WIDTH-1:0] stat_frames,
    output logic [CNT_WIDTH-1:0] stat_keys,
    output logic [CNT_WIDTH-1:0] stat_drops
);

    localparam logic [1:0] c_RESYNC = 2'd0;
    localparam logic [1:0] c_HDR    = 2'd1;
    localparam logic [1:0] c_SKIP   = 2'd2;

    logic [1:0]           r_state;
    logic [2:0]           r_bcnt;
    logic                 r_bad;
    logic [31:0]          r_src_ip;
    logic [15:0]          r_dst_hi;
    logic                 r_tready;
    logic [KEY_SIZE-1:0]  r_key;
    logic [3:0]           r_flag;
    logic                 r_valid;
    logic [CNT_WIDTH-1:0] r_frames;
    logic [CNT_WIDTH-1:0] r_keys;
    logic [CNT_WIDTH-1:0] r_drops;

    logic [7:0]           w_lane [8];
    logic                 w_acc;
    logic                 w_chk_fail;
    logic [31:0]          w_dst_ip;
    logic [15:0]          w_sport;
    logic [15:0]          w_dport;
    logic                 w_emit;
    logic [3:0]           w_flag;
    logic [KEY_SIZE-1:0]  w_key;
    logic                 w_unused;

    for (genvar k = 0; k < 8; k++) begin : g_lane
        assign w_lane[k] = s_axis_tdata[8*k +: 8];
    end

    assign w_unused = ^s_axis_tkeep;
    assign w_acc    = s_axis_tvalid & r_tready;

    always_comb begin
        w_chk_fail = 1'b0;
        if (r_bcnt == 3'd1)
            w_chk_fail = ({w_lane[4], w_lane[5]} != 16'h0800) || (w_lane[6] != 8'h45);
        else if (r_bcnt == 3'd2)
            w_chk_fail = (({w_lane[4], w_lane[5]} & 16'h3FFF) != 16'h0000) || (w_lane[7] != 8'h11);
    end

    assign w_dst_ip = {r_dst_hi, w_lane[0], w_lane[1]};
    assign w_sport  = {w_lane[2], w_lane[3]};
    assign w_dport  = {w_lane[4], w_lane[5]};

    // Query rule takes priority so a DNS-to-DNS frame is always an insert.
    always_comb begin
        w_emit = 1'b0;
        w_flag = 4'h0;
        w_key  = '0;
        if (w_dport == DNS_PORT) begin
            w_emit = 1'b1;
            w_flag = 4'h1;
            w_key  = {r_src_ip, w_dst_ip, w_sport, 16'h0000};
        end else if (w_sport == DNS_PORT) begin
            w_emit = 1'b1;
            w_flag = 4'h2;
            w_key  = {w_dst_ip, r_src_ip, w_dport, 16'h0000};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_RESYNC;
            r_bcnt   <= 3'd0;
            r_bad    <= 1'b0;
            r_src_ip <= 32'h0;
            r_dst_hi <= 16'h0;
            r_tready <= 1'b0;
            r_key    <= '0;
            r_flag   <= 4'h0;
            r_valid  <= 1'b0;
            r_frames <= '0;
            r_keys   <= '0;
            r_drops  <= '0;
        end else begin
            r_tready <= 1'b1;
            r_valid  <= 1'b0;
            if (w_acc) begin
                case (r_state)
                    c_RESYNC: begin
                        if (s_axis_tlast) begin
                            r_state <= c_HDR;
                            r_bcnt  <= 3'd0;
                            r_bad   <= 1'b0;
                        end
                    end
                    c_SKIP: begin
                        if (s_axis_tlast) begin
                            r_frames <= r_frames + 1'b1;
                            r_state  <= c_HDR;
                            r_bcnt   <= 3'd0;
                            r_bad    <= 1'b0;
                        end
                    end
                    c_HDR: begin
                        if (s_axis_tlast)
                            r_frames <= r_frames + 1'b1;
                        if (r_bcnt == 3'd4) begin
                            if (!r_bad && w_emit) begin
                                r_valid <= 1'b1;
                                r_key   <= w_key;
                                r_flag  <= w_flag;
                                r_keys  <= r_keys + 1'b1;
                            end
                            r_bcnt  <= 3'd0;
                            r_bad   <= 1'b0;
                            r_state <= s_axis_tlast ? c_HDR : c_SKIP;
                        end else if (s_axis_tlast) begin
                            // Runt: header ended before the UDP ports arrived.
                            r_drops <= r_drops + 1'b1;
                            r_bcnt  <= 3'd0;
                            r_bad   <= 1'b0;
                        end else begin
                            r_bcnt <= r_bcnt + 3'd1;
                            if (w_chk_fail)
                                r_bad <= 1'b1;
                            if (r_bcnt == 3'd3) begin
                                r_src_ip <= {w_lane[2], w_lane[3], w_lane[4], w_lane[5]};
                                r_dst_hi <= {w_lane[6], w_lane[7]};
                            end
                        end
                    end
                    default: r_state <= c_RESYNC;
                endcase
            end
        end
    end

    assign s_axis_tready = r_tready;
    assign out_key       = r_key;
    assign out_flag      = r_flag;
    assign out_valid     = r_valid;
    assign stat_frames   = r_frames;
    assign stat_keys     = r_keys;
    assign stat_drops    = r_drops;

endmodule
`default_nettype wire

// File: tb/tb_db_key_extract.sv
`default_nettype none
// ============================================================================
// Module      : tb_db_key_extract
// Description : Self-checking bench: directed vector table, reset corner case
//               and randomized frames against a byte-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_db_key_extract;

    logic        clk;
    logic        rst_n;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic [95:0] out_key;
    logic [3:0]  out_flag;
    logic        out_valid;
    logic [31:0] stat_frames;
    logic [31:0] stat_keys;
    logic [31:0] stat_drops;

    db_key_extract #(.KEY_SIZE(96), .DNS_PORT(16'd53), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
        .s_axis_tlast(tlast), .s_axis_tready(tready),
        .out_key(out_key), .out_flag(out_flag), .out_valid(out_valid),
        .stat_frames(stat_frames), .stat_keys(stat_keys), .stat_drops(stat_drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int pulses = 0;

    always @(negedge clk) if (out_valid === 1'b1) pulses++;

    logic [7:0]  fb [0:71];
    logic        in_resync;
    int          exp_frames, exp_keys, exp_drops;
    logic [95:0] exp_last_key;
    logic [3:0]  exp_last_flag;

    typedef struct {
        logic [15:0] et;
        logic [7:0]  vihl;
        logic [15:0] flg;
        logic [7:0]  proto;
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] sp;
        logic [15:0] dp;
        int          nb;
        int          gb;
        int          gl;
        logic        ev;
        logic [3:0]  ef;
        logic [95:0] ek;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic build(input logic [15:0] et, input logic [7:0] vihl, input logic [15:0] flg,
                         input logic [7:0] proto, input logic [31:0] src, input logic [31:0] dst,
                         input logic [15:0] sp, input logic [15:0] dp);
        for (int i = 0; i < 72; i++) fb[i] = 8'($urandom);
        {fb[12], fb[13]} = et;
        fb[14] = vihl;
        {fb[20], fb[21]} = flg;
        fb[23] = proto;
        {fb[26], fb[27], fb[28], fb[29]} = src;
        {fb[30], fb[31], fb[32], fb[33]} = dst;
        {fb[34], fb[35]} = sp;
        {fb[36], fb[37]} = dp;
    endtask

    // Reference: frame bytes in wire order, decoded by header byte offsets.
    task automatic model(input int nb, output logic v, output logic [3:0] f, output logic [95:0] k);
        logic        ok;
        logic [31:0] src, dst;
        logic [15:0] sp, dp;
        ok  = ({fb[12], fb[13]} == 16'h0800) && (fb[14] == 8'h45) &&
              (({fb[20], fb[21]} & 16'h3FFF) == 16'h0) && (fb[23] == 8'h11);
        src = {fb[26], fb[27], fb[28], fb[29]};
        dst = {fb[30], fb[31], fb[32], fb[33]};
        sp  = {fb[34], fb[35]};
        dp  = {fb[36], fb[37]};
        v = 1'b0; f = 4'h0; k = '0;
        if (nb >= 5 && ok) begin
            if (dp == 16'd53) begin
                v = 1'b1; f = 4'h1; k = {src, dst, sp, 16'h0};
            end else if (sp == 16'd53) begin
                v = 1'b1; f = 4'h2; k = {dst, src, dp, 16'h0};
            end
        end
    endtask

    task automatic send_frame(input string tag, input int nb, input int gb, input int gl,
                              input logic ev_in, input logic [3:0] ef, input logic [95:0] ek);
        int   p0;
        logic ev;
        ev = in_resync ? 1'b0 : ev_in;
        p0 = pulses;
        for (int b = 0; b < nb; b++) begin
            if (b == gb) begin
                tvalid = 1'b0;
                tdata  = {$urandom, $urandom};
                tlast  = 1'b1;
                repeat (gl) @(posedge clk);
                #1;
            end
            tdata  = {fb[8*b+7], fb[8*b+6], fb[8*b+5], fb[8*b+4],
                      fb[8*b+3], fb[8*b+2], fb[8*b+1], fb[8*b]};
            tvalid = 1'b1;
            tlast  = (b == nb - 1);
            @(posedge clk);
            #1;
            if (b == 4) chk({tag, "_latency"}, 128'(out_valid), 128'(ev));
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (in_resync) begin
            in_resync = 1'b0;
        end else begin
            exp_frames++;
            if (nb < 5) exp_drops++;
            if (ev) begin
                exp_keys++;
                exp_last_key  = ek;
                exp_last_flag = ef;
            end
        end
        chk({tag, "_pulses"}, 128'(pulses - p0), 128'(ev ? 1 : 0));
        chk({tag, "_key"},    128'(out_key),     128'(exp_last_key));
        chk({tag, "_flag"},   128'(out_flag),    128'(exp_last_flag));
        chk({tag, "_frames"}, 128'(stat_frames), 128'(exp_frames));
        chk({tag, "_keys"},   128'(stat_keys),   128'(exp_keys));
        chk({tag, "_drops"},  128'(stat_drops),  128'(exp_drops));
    endtask

    initial begin
        logic        mv;
        logic [3:0]  mf;
        logic [95:0] mk;
        logic [15:0] et, flg, sp, dp;
        logic [7:0]  vihl, proto;
        int          nb, gb;

        tbl[0]  = '{16'h0800, 8'h45, 16'h0000, 8'h11, 32'h0A000001, 32'h08080808, 16'h0FA0, 16'h0035, 8, -1, 0, 1'b1, 4'h1, 96'h0A000001_08080808_0FA0_0000};
        tbl[1]  = '{16'h0800, 8'h45, 16'h0000, 8'h11, 32'h08080808, 32'h0A000001, 16'h0035, 16'h0FA0, 8, -1, 0, 1'b1, 4'h2, 96'h0A000001_08080808_0FA0_0000};
        tbl[2]  = '{16'h86DD, 8'h45, 16'h0000, 8'h11, 32'h0A000001, 32'h08080808, 16'h0FA0, 16'h0035, 8, -1, 0, 1'b0, 4'h0, 96'h0};
        tbl[3]  = '{16'h0800, 8'h45, 16'h0000, 8'h06, 32'h0A000001, 32'h08080808, 16'h0FA0, 16'h0035, 8, -1, 0, 1'b0, 4'h0, 96'h0};
        tbl[4]  = '{16'h0800, 8'h45, 16'h2000, 8'h11, 32'h0A000001, 32'h08080808, 16'h0FA0, 16'h0035, 8, -1, 0, 1'b0, 4'h0, 96'h0};
        tbl[5]  = '{16'h0800, 8'h45, 16'h0000, 8'h11, 32'h0A000001, 32'h08080808, 16'h0FA0, 16'h007B, 8, -1, 0, 1'b0, 4'h0, 96'h0};
        tbl[6]  = '{16'h0800, 8'h45, 16'h0000, 8'h11, 32'h0A000001, 32'h08080808, 16'h0FA0, 16'h0035, 3, -1, 0, 1'b0, 4'h0, 96'h0};
        tbl[7]  = '{16'h0800, 8'h45, 16'h0000, 8'h11, 32'h0A000001, 32'h08080808, 16'h0FA0, 16'h0035, 8, -1, 0, 1'b1, 4'h1, 96'h0A000001_08080808_0FA0_0000};
        tbl[8]  = '{16'h0800, 8'h45, 16'h0000, 8'h11, 32'h0A000001, 32'h08080808, 16'h0FA0, 16'h0035, 8,  3, 5, 1'b1, 4'h1, 96'h0A000001_08080808_0FA0_0000};
        tbl[9]  = '{16'h0800, 8'h45, 16'h0000, 8'h11, 32'hC0A80001, 32'hC0A80002, 16'h0035, 16'h0035, 8, -1, 0, 1'b1, 4'h1, 96'hC0A80001_C0A80002_0035_0000};
        tbl[10] = '{16'h0800, 8'h45, 16'h4000, 8'h11, 32'h0A000002, 32'h01010101, 16'h1234, 16'h0035, 8, -1, 0, 1'b1, 4'h1, 96'h0A000002_01010101_1234_0000};
        tbl[11] = '{16'h0800, 8'h45, 16'h0000, 8'h11, 32'h01010101, 32'h0A000002, 16'h0035, 16'h1234, 5, -1, 0, 1'b1, 4'h2, 96'h0A000002_01010101_1234_0000};
        tbl[12] = '{16'h8100, 8'h45, 16'h0000, 8'h11, 32'h0A000001, 32'h08080808, 16'h0FA0, 16'h0035, 8, -1, 0, 1'b0, 4'h0, 96'h0};
        tbl[13] = '{16'h0800, 8'h46, 16'h0000, 8'h11, 32'h0A000001, 32'h08080808, 16'h0FA0, 16'h0035, 8, -1, 0, 1'b0, 4'h0, 96'h0};
        tbl[14] = '{16'h0800, 8'h45, 16'h0000, 8'h11, 32'h0A000001, 32'h08080808, 16'h0FA0, 16'h0035, 4, -1, 0, 1'b0, 4'h0, 96'h0};
        tbl[15] = '{16'h0800, 8'h45, 16'h0001, 8'h11, 32'h0A000001, 32'h08080808, 16'h0FA0, 16'h0035, 8, -1, 0, 1'b0, 4'h0, 96'h0};

        rst_n = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0; tkeep = 8'hFF;
        in_resync = 1'b1; exp_frames = 0; exp_keys = 0; exp_drops = 0;
        exp_last_key = '0; exp_last_flag = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", 128'(tready),    128'(0));
        chk("rst_valid",  128'(out_valid), 128'(0));
        chk("rst_key",    128'(out_key),   128'(0));
        chk("rst_flag",   128'(out_flag),  128'(0));
        chk("rst_stats",  128'({stat_frames, stat_keys, stat_drops}), 128'(0));
        rst_n = 1'b1;
        #1 chk("tready_pre_edge", 128'(tready), 128'(0));
        @(posedge clk);
        #1 chk("tready_up", 128'(tready), 128'(1));

        // First frame after reset is consumed by resynchronisation.
        build(16'h0800, 8'h45, 16'h0, 8'h11, 32'h0A000001, 32'h08080808, 16'h0FA0, 16'h0035);
        send_frame("dummy", 8, -1, 0, 1'b1, 4'h1, 96'h0A000001_08080808_0FA0_0000);

        for (int i = 0; i < 16; i++) begin
            build(tbl[i].et, tbl[i].vihl, tbl[i].flg, tbl[i].proto, tbl[i].src, tbl[i].dst, tbl[i].sp, tbl[i].dp);
            send_frame($sformatf("vec%0d", i), tbl[i].nb, tbl[i].gb, tbl[i].gl, tbl[i].ev, tbl[i].ef, tbl[i].ek);
        end

        // Reset in the middle of beat 2; the interrupted frame is abandoned.
        build(16'h0800, 8'h45, 16'h0, 8'h11, 32'h0A000001, 32'h08080808, 16'h0FA0, 16'h0035);
        for (int b = 0; b < 3; b++) begin
            tdata  = {fb[8*b+7], fb[8*b+6], fb[8*b+5], fb[8*b+4], fb[8*b+3], fb[8*b+2], fb[8*b+1], fb[8*b]};
            tvalid = 1'b1;
            tlast  = 1'b0;
            if (b < 2) begin
                @(posedge clk);
                #1;
            end
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid",  128'(out_valid),   128'(0));
        chk("midrst_key",    128'(out_key),     128'(0));
        chk("midrst_flag",   128'(out_flag),    128'(0));
        chk("midrst_keys",   128'(stat_keys),   128'(0));
        chk("midrst_frames", 128'(stat_frames), 128'(0));
        chk("midrst_tready", 128'(tready),      128'(0));
        tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        in_resync = 1'b1; exp_frames = 0; exp_keys = 0; exp_drops = 0;
        exp_last_key = '0; exp_last_flag = 4'h0;
        @(posedge clk);
        #1;
        build(16'h0800, 8'h45, 16'h0, 8'h11, 32'h0A000001, 32'h08080808, 16'h0FA0, 16'h0035);
        send_frame("post_rst1", 8, -1, 0, 1'b1, 4'h1, 96'h0A000001_08080808_0FA0_0000);
        build(16'h0800, 8'h45, 16'h0, 8'h11, 32'h0A000001, 32'h08080808, 16'h0FA0, 16'h0035);
        send_frame("post_rst2", 8, -1, 0, 1'b1, 4'h1, 96'h0A000001_08080808_0FA0_0000);

        for (int i = 0; i < 60; i++) begin
            et    = ($urandom_range(0, 5) != 0) ? 16'h0800 : 16'($urandom);
            vihl  = ($urandom_range(0, 7) != 0) ? 8'h45 : 8'($urandom);
            flg   = ($urandom_range(0, 3) != 0) ? 16'($urandom_range(0, 1) << 14) : 16'($urandom);
            proto = ($urandom_range(0, 5) != 0) ? 8'h11 : 8'($urandom);
            sp    = ($urandom_range(0, 2) == 0) ? 16'd53 : 16'($urandom);
            dp    = ($urandom_range(0, 2) == 0) ? 16'd53 : 16'($urandom);
            nb    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 9));
            gb    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : -1;
            build(et, vihl, flg, proto, $urandom, $urandom, sp, dp);
            model(nb, mv, mf, mk);
            send_frame($sformatf("rnd%0d", i), nb, gb, int'($urandom_range(1, 4)), mv, mf, mk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
